// File: rtl/branch_redirect_ctrl_if.sv
// ============================================================================
// Module      : branch_redirect_ctrl_if
// Description : Compare-stage resolution inputs and fetch redirect handshake.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface branch_redirect_ctrl_if #(
    parameter int ADDR_WIDTH = 32
);
    logic                  bundle_valid;
    logic                  bne1;
    logic                  bne2;
    logic                  bne3;
    logic                  bne4;
    logic [ADDR_WIDTH-1:0] ins1_target;
    logic [ADDR_WIDTH-1:0] ins2_target;
    logic [ADDR_WIDTH-1:0] ins3_target;
    logic [ADDR_WIDTH-1:0] ins4_target;
    logic                  redirect_ready;
    logic                  redirect_valid;
    logic [ADDR_WIDTH-1:0] redirect_pc;
    logic [3:0]            kill_mask;
    logic                  flush_front;
    logic                  busy;

    // Pipeline/fetch side: drives resolutions and the ready, observes the redirect.
    modport master (
        output bundle_valid, bne1, bne2, bne3, bne4,
        output ins1_target, ins2_target, ins3_target, ins4_target,
        output redirect_ready,
        input  redirect_valid, redirect_pc, kill_mask, flush_front, busy
    );

    modport slave (
        input  bundle_valid, bne1, bne2, bne3, bne4,
        input  ins1_target, ins2_target, ins3_target, ins4_target,
        input  redirect_ready,
        output redirect_valid, redirect_pc, kill_mask, flush_front, busy
    );
endinterface

`default_nettype wire

// File: rtl/branch_redirect_ctrl.sv
// ============================================================================
// Module      : branch_redirect_ctrl
// Description : Picks the oldest mispredicting slot of a 4-wide bundle, issues
//               a redirect to fetch and holds a front-end flush while draining.
//               Optional statistics counters: define BRANCH_STATS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module branch_redirect_ctrl #(
    parameter int ADDR_WIDTH   = 32,
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                 clk,
    input  logic                 rst,
`ifdef BRANCH_STATS_EN
    output logic [CNT_WIDTH-1:0] mispredict_cnt,
    output logic [CNT_WIDTH-1:0] redirect_stall_cnt,
`endif
    branch_redirect_ctrl_if.slave bus
);

    localparam int c_DRAIN_W = (FLUSH_CYCLES < 2) ? 1 : $clog2(FLUSH_CYCLES + 1);
    localparam logic [c_DRAIN_W-1:0] c_DRAIN_INIT = c_DRAIN_W'(FLUSH_CYCLES);
    localparam logic [c_DRAIN_W-1:0] c_DRAIN_LAST = c_DRAIN_W'(1);

    localparam logic [1:0] c_IDLE     = 2'd0;
    localparam logic [1:0] c_REDIRECT = 2'd1;
    localparam logic [1:0] c_DRAIN    = 2'd2;

    if ((CNT_WIDTH < 1) || (ADDR_WIDTH < 1) || (FLUSH_CYCLES < 0)) begin : g_param_check
        $error("branch_redirect_ctrl: illegal parameter value");
    end

    logic [1:0]            r_state;
    logic [1:0]            w_state_nxt;
    logic [c_DRAIN_W-1:0]  r_drain_cnt;
    logic [c_DRAIN_W-1:0]  w_drain_nxt;
    logic [ADDR_WIDTH-1:0] r_redirect_pc;
    logic [3:0]            r_kill_mask;
    logic [ADDR_WIDTH-1:0] w_win_target;
    logic [3:0]            w_win_kill;
    logic                  w_any_bne;
    logic                  w_trigger;

    // Flags are only meaningful for a real bundle and only while nothing is in flight.
    assign w_any_bne = bus.bne1 | bus.bne2 | bus.bne3 | bus.bne4;
    assign w_trigger = (r_state == c_IDLE) && bus.bundle_valid && w_any_bne;

    // Oldest slot wins; everything younger in the bundle is squashed.
    always_comb begin
        w_win_target = bus.ins4_target;
        w_win_kill   = 4'b0000;
        if (bus.bne1) begin
            w_win_target = bus.ins1_target;
            w_win_kill   = 4'b1110;
        end else if (bus.bne2) begin
            w_win_target = bus.ins2_target;
            w_win_kill   = 4'b1100;
        end else if (bus.bne3) begin
            w_win_target = bus.ins3_target;
            w_win_kill   = 4'b1000;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= c_IDLE;
            r_drain_cnt <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_drain_cnt <= w_drain_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_drain_nxt = r_drain_cnt;
        case (r_state)
            c_IDLE: begin
                if (w_trigger) begin
                    w_state_nxt = c_REDIRECT;
                end
            end
            c_REDIRECT: begin
                if (bus.redirect_ready) begin
                    if (FLUSH_CYCLES == 0) begin
                        w_state_nxt = c_IDLE;
                    end else begin
                        w_state_nxt = c_DRAIN;
                        w_drain_nxt = c_DRAIN_INIT;
                    end
                end
            end
            c_DRAIN: begin
                w_drain_nxt = r_drain_cnt - 1'b1;
                if (r_drain_cnt <= c_DRAIN_LAST) begin
                    w_state_nxt = c_IDLE;
                end
            end
            default: begin
                w_state_nxt = c_IDLE;
                w_drain_nxt = '0;
            end
        endcase
    end

    // State is registered, so these decodes change only on clock or reset.
    always_comb begin
        bus.redirect_valid = (r_state == c_REDIRECT);
        bus.flush_front    = (r_state != c_IDLE);
        bus.busy           = (r_state != c_IDLE);
        bus.redirect_pc    = r_redirect_pc;
        bus.kill_mask      = r_kill_mask;
    end

    // kill_mask applies only to the bundle in the next stage, hence one-cycle pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_redirect_pc <= '0;
            r_kill_mask   <= 4'b0000;
        end else begin
            r_kill_mask <= 4'b0000;
            if (w_trigger) begin
                r_redirect_pc <= w_win_target;
                r_kill_mask   <= w_win_kill;
            end
        end
    end

`ifdef BRANCH_STATS_EN
    localparam logic [CNT_WIDTH-1:0] c_CNT_MAX = '1;

    logic [CNT_WIDTH-1:0] r_mispredict_cnt;
    logic [CNT_WIDTH-1:0] r_stall_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mispredict_cnt <= '0;
            r_stall_cnt      <= '0;
        end else begin
            if (w_trigger && (r_mispredict_cnt != c_CNT_MAX)) begin
                r_mispredict_cnt <= r_mispredict_cnt + 1'b1;
            end
            if ((r_state == c_REDIRECT) && !bus.redirect_ready && (r_stall_cnt != c_CNT_MAX)) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
        end
    end

    assign mispredict_cnt     = r_mispredict_cnt;
    assign redirect_stall_cnt = r_stall_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_branch_redirect_ctrl.sv
// ============================================================================
// Module      : tb_branch_redirect_ctrl
// Description : Two DUTs (FLUSH_CYCLES=2 / FLUSH_CYCLES=0 with 2-bit counters)
//               driven from the same stimulus and compared to a transaction model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_branch_redirect_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        bv;
    logic [3:0]  bne;
    logic [31:0] tgt [4];
    logic        rdy;

    int errors = 0;
    int checks = 0;

    branch_redirect_ctrl_if #(.ADDR_WIDTH(32)) if0 ();
    branch_redirect_ctrl_if #(.ADDR_WIDTH(32)) if1 ();

    assign if0.bundle_valid = bv;   assign if1.bundle_valid = bv;
    assign if0.bne1 = bne[0];       assign if1.bne1 = bne[0];
    assign if0.bne2 = bne[1];       assign if1.bne2 = bne[1];
    assign if0.bne3 = bne[2];       assign if1.bne3 = bne[2];
    assign if0.bne4 = bne[3];       assign if1.bne4 = bne[3];
    assign if0.ins1_target = tgt[0]; assign if1.ins1_target = tgt[0];
    assign if0.ins2_target = tgt[1]; assign if1.ins2_target = tgt[1];
    assign if0.ins3_target = tgt[2]; assign if1.ins3_target = tgt[2];
    assign if0.ins4_target = tgt[3]; assign if1.ins4_target = tgt[3];
    assign if0.redirect_ready = rdy; assign if1.redirect_ready = rdy;

    logic [15:0] w_mis   [2];
    logic [15:0] w_stall [2];

`ifdef BRANCH_STATS_EN
    logic [15:0] mis0, stall0;
    logic [1:0]  mis1, stall1;
    branch_redirect_ctrl #(.ADDR_WIDTH(32), .FLUSH_CYCLES(2), .CNT_WIDTH(16)) dut0 (
        .clk(clk), .rst(rst), .mispredict_cnt(mis0), .redirect_stall_cnt(stall0), .bus(if0.slave));
    branch_redirect_ctrl #(.ADDR_WIDTH(32), .FLUSH_CYCLES(0), .CNT_WIDTH(2)) dut1 (
        .clk(clk), .rst(rst), .mispredict_cnt(mis1), .redirect_stall_cnt(stall1), .bus(if1.slave));
    assign w_mis[0] = mis0;            assign w_stall[0] = stall0;
    assign w_mis[1] = {14'b0, mis1};   assign w_stall[1] = {14'b0, stall1};
`else
    branch_redirect_ctrl #(.ADDR_WIDTH(32), .FLUSH_CYCLES(2), .CNT_WIDTH(16)) dut0 (
        .clk(clk), .rst(rst), .bus(if0.slave));
    branch_redirect_ctrl #(.ADDR_WIDTH(32), .FLUSH_CYCLES(0), .CNT_WIDTH(2)) dut1 (
        .clk(clk), .rst(rst), .bus(if1.slave));
    assign w_mis[0] = 16'd0; assign w_stall[0] = 16'd0;
    assign w_mis[1] = 16'd0; assign w_stall[1] = 16'd0;
`endif

    logic        w_valid [2];
    logic        w_flush [2];
    logic        w_busy  [2];
    logic [3:0]  w_kill  [2];
    logic [31:0] w_pc    [2];
    assign w_valid[0] = if0.redirect_valid; assign w_valid[1] = if1.redirect_valid;
    assign w_flush[0] = if0.flush_front;    assign w_flush[1] = if1.flush_front;
    assign w_busy[0]  = if0.busy;           assign w_busy[1]  = if1.busy;
    assign w_kill[0]  = if0.kill_mask;      assign w_kill[1]  = if1.kill_mask;
    assign w_pc[0]    = if0.redirect_pc;    assign w_pc[1]    = if1.redirect_pc;

    always #5 clk = ~clk;

    // Transaction-level model: one outstanding redirect, then a countdown of flush cycles.
    bit          m_pending    [2];
    int          m_flush_left [2];
    logic [31:0] m_pc         [2];
    logic [3:0]  m_kill       [2];
    int          m_cnt        [2];
    int          m_stall      [2];
    int          c_flush [2] = '{2, 0};
    int          c_sat   [2] = '{65535, 3};

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_pending[d] = 1'b0; m_flush_left[d] = 0; m_pc[d] = 32'd0;
            m_kill[d] = 4'd0; m_cnt[d] = 0; m_stall[d] = 0;
        end
    endtask

    task automatic tick();
        for (int d = 0; d < 2; d++) begin
            int w;
            m_kill[d] = 4'b0000;
            if (m_pending[d]) begin
                if (rdy) begin
                    m_pending[d]    = 1'b0;
                    m_flush_left[d] = c_flush[d];
                end else if (m_stall[d] < c_sat[d]) begin
                    m_stall[d]++;
                end
            end else if (m_flush_left[d] > 0) begin
                m_flush_left[d]--;
            end else if (bv && (bne != 4'b0000)) begin
                w = 1;
                while (!bne[w-1]) w++;
                m_pending[d] = 1'b1;
                m_pc[d]      = tgt[w-1];
                m_kill[d]    = 4'b1111 << w;
                if (m_cnt[d] < c_sat[d]) m_cnt[d]++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        bv = 1'b0; bne = 4'b0000; rdy = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic idle_ticks(input int n);
        bv = 1'b0; bne = 4'b0000;
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic test_reset();
        apply_reset();
        checks++; if (w_valid[0] !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", w_valid[0]); end
        checks++; if (w_flush[0] !== 1'b0) begin errors++; $display("FAIL reset_flush got=%b exp=0", w_flush[0]); end
        checks++; if (w_busy[0] !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", w_busy[0]); end
        checks++; if (w_kill[0] !== 4'b0000) begin errors++; $display("FAIL reset_kill got=%b exp=0000", w_kill[0]); end
        checks++; if (w_pc[0] !== 32'd0) begin errors++; $display("FAIL reset_pc got=%h exp=0", w_pc[0]); end
`ifdef BRANCH_STATS_EN
        checks++; if (w_mis[0] !== 16'd0 || w_stall[0] !== 16'd0) begin
            errors++; $display("FAIL reset_stats got=%0d/%0d exp=0/0", w_mis[0], w_stall[0]); end
`endif
        // Asynchronous reset while a redirect is outstanding.
        bv = 1'b1; bne = 4'b0001; tgt[0] = 32'hDEAD_0000; rdy = 1'b0;
        tick();
        checks++; if (w_valid[0] !== 1'b1) begin errors++; $display("FAIL midreset_pre_valid got=%b exp=1", w_valid[0]); end
        #2 rst = 1'b1;
        #1;
        checks++; if ({w_valid[0], w_flush[0], w_busy[0]} !== 3'b000) begin
            errors++; $display("FAIL midreset_async got=%b exp=000", {w_valid[0], w_flush[0], w_busy[0]}); end
        checks++; if (w_pc[0] !== 32'd0 || w_kill[0] !== 4'd0) begin
            errors++; $display("FAIL midreset_pc_kill got=%h/%b exp=0/0000", w_pc[0], w_kill[0]); end
        bv = 1'b0; bne = 4'b0000;
        @(posedge clk);
        #1 rst = 1'b0;
        model_reset();
        tick();
        checks++; if (w_busy[0] !== 1'b0) begin errors++; $display("FAIL midreset_post_busy got=%b exp=0", w_busy[0]); end
    endtask

    task automatic test_single_slot2();
        apply_reset();
        rdy = 1'b1; bv = 1'b1; bne = 4'b0010; tgt[1] = 32'h0000_0400;
        tick();
        bv = 1'b0; bne = 4'b0000;
        checks++; if (w_valid[0] !== 1'b1 || w_pc[0] !== 32'h400) begin
            errors++; $display("FAIL slot2_redirect got=%b/%h exp=1/00000400", w_valid[0], w_pc[0]); end
        checks++; if (w_kill[0] !== 4'b1100) begin errors++; $display("FAIL slot2_kill got=%b exp=1100", w_kill[0]); end
        checks++; if (w_flush[0] !== 1'b1) begin errors++; $display("FAIL slot2_flush_n1 got=%b exp=1", w_flush[0]); end
        tick();
        checks++; if ({w_valid[0], w_flush[0], w_kill[0]} !== 6'b010000) begin
            errors++; $display("FAIL slot2_n2 got=%b exp=010000", {w_valid[0], w_flush[0], w_kill[0]}); end
        tick();
        checks++; if (w_flush[0] !== 1'b1 || w_busy[0] !== 1'b1) begin
            errors++; $display("FAIL slot2_n3 got=%b%b exp=11", w_flush[0], w_busy[0]); end
        tick();
        checks++; if (w_flush[0] !== 1'b0 || w_busy[0] !== 1'b0) begin
            errors++; $display("FAIL slot2_n4 got=%b%b exp=00", w_flush[0], w_busy[0]); end
    endtask

    task automatic test_multi_flag();
        int rises;
        logic prev;
        apply_reset();
        rdy = 1'b1; bv = 1'b1; bne = 4'b1010; tgt[1] = 32'h100; tgt[3] = 32'h200;
        prev = w_valid[0];
        tick();
        bv = 1'b0; bne = 4'b0000;
        checks++; if (w_pc[0] !== 32'h100 || w_kill[0] !== 4'b1100) begin
            errors++; $display("FAIL multi_pc_kill got=%h/%b exp=00000100/1100", w_pc[0], w_kill[0]); end
        rises = (w_valid[0] && !prev) ? 1 : 0;
        prev = w_valid[0];
        for (int i = 0; i < 8; i++) begin
            tick();
            if (w_valid[0] && !prev) rises++;
            prev = w_valid[0];
        end
        checks++; if (rises !== 1) begin errors++; $display("FAIL multi_redirect_count got=%0d exp=1", rises); end
    endtask

    task automatic test_backpressure();
        apply_reset();
        rdy = 1'b0; bv = 1'b1; bne = 4'b0001; tgt[0] = 32'h0000_00A0;
        tick();
        tgt[0] = 32'h0000_0BBB;
        for (int i = 0; i < 4; i++) begin
            checks++; if (w_valid[0] !== 1'b1 || w_pc[0] !== 32'hA0) begin
                errors++; $display("FAIL bp_hold cyc%0d got=%b/%h exp=1/000000a0", i, w_valid[0], w_pc[0]); end
            if (i == 3) begin bv = 1'b0; bne = 4'b0000; rdy = 1'b1; end
            tick();
        end
        checks++; if (w_valid[0] !== 1'b0) begin errors++; $display("FAIL bp_release got=%b exp=0", w_valid[0]); end
`ifdef BRANCH_STATS_EN
        checks++; if (w_stall[0] !== 16'd3) begin errors++; $display("FAIL bp_stall_cnt got=%0d exp=3", w_stall[0]); end
        checks++; if (w_mis[0] !== 16'd1) begin errors++; $display("FAIL bp_mis_cnt got=%0d exp=1", w_mis[0]); end
`endif
        idle_ticks(4);
        checks++; if (w_busy[0] !== 1'b0 || w_valid[0] !== 1'b0) begin
            errors++; $display("FAIL bp_injected_ignored got=%b%b exp=00", w_busy[0], w_valid[0]); end
    endtask

    task automatic test_edges();
        apply_reset();
        rdy = 1'b1; bv = 1'b1; bne = 4'b1000; tgt[3] = 32'h0000_4444;
        tick();
        checks++; if (w_kill[0] !== 4'b0000 || w_pc[0] !== 32'h4444 || w_valid[0] !== 1'b1) begin
            errors++; $display("FAIL edge_slot4 got=%b/%h/%b exp=0000/00004444/1", w_kill[0], w_pc[0], w_valid[0]); end
        idle_ticks(5);
        bv = 1'b1; bne = 4'b0001; tgt[0] = 32'h0000_1111;
        tick();
        checks++; if (w_kill[0] !== 4'b1110 || w_pc[0] !== 32'h1111) begin
            errors++; $display("FAIL edge_slot1 got=%b/%h exp=1110/00001111", w_kill[0], w_pc[0]); end
        idle_ticks(5);
        bv = 1'b0; bne = 4'b0001;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (w_busy[0] !== 1'b0 || w_valid[0] !== 1'b0) begin
                errors++; $display("FAIL edge_bubble cyc%0d got=%b%b exp=00", i, w_busy[0], w_valid[0]); end
        end
    endtask

    task automatic test_back_to_back();
        apply_reset();
        rdy = 1'b1; bv = 1'b1; bne = 4'b0001; tgt[0] = 32'h0000_A000;
        tick();
        checks++; if (w_valid[1] !== 1'b1 || w_pc[1] !== 32'hA000) begin
            errors++; $display("FAIL b2b_first got=%b/%h exp=1/0000a000", w_valid[1], w_pc[1]); end
        tgt[0] = 32'h0000_B000;
        tick();
        checks++; if (w_valid[1] !== 1'b0 || w_busy[1] !== 1'b0) begin
            errors++; $display("FAIL b2b_gap got=%b%b exp=00", w_valid[1], w_busy[1]); end
        tick();
        bv = 1'b0; bne = 4'b0000;
        checks++; if (w_valid[1] !== 1'b1 || w_pc[1] !== 32'hB000) begin
            errors++; $display("FAIL b2b_second got=%b/%h exp=1/0000b000", w_valid[1], w_pc[1]); end
        tick();
`ifdef BRANCH_STATS_EN
        checks++; if (w_mis[1] !== 16'd2) begin errors++; $display("FAIL b2b_mis_cnt got=%0d exp=2", w_mis[1]); end
        for (int i = 0; i < 4; i++) begin
            bv = 1'b1; bne = 4'b0100; tick();
            bv = 1'b0; bne = 4'b0000; tick();
        end
        checks++; if (w_mis[1] !== 16'd3) begin errors++; $display("FAIL b2b_mis_saturate got=%0d exp=3", w_mis[1]); end
`endif
    endtask

    task automatic test_random();
        apply_reset();
        for (int c = 0; c < 400; c++) begin
            bv  = ($urandom_range(0, 4) != 0);
            bne = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0000;
            rdy = ($urandom_range(0, 2) != 0);
            for (int s = 0; s < 4; s++) tgt[s] = $urandom;
            tick();
            for (int d = 0; d < 2; d++) begin
                checks++; if (w_valid[d] !== m_pending[d]) begin
                    errors++; $display("FAIL rand_valid dut%0d cyc%0d got=%b exp=%b", d, c, w_valid[d], m_pending[d]); end
                checks++; if (w_flush[d] !== (m_pending[d] || m_flush_left[d] > 0)) begin
                    errors++; $display("FAIL rand_flush dut%0d cyc%0d got=%b", d, c, w_flush[d]); end
                checks++; if (w_busy[d] !== (m_pending[d] || m_flush_left[d] > 0)) begin
                    errors++; $display("FAIL rand_busy dut%0d cyc%0d got=%b", d, c, w_busy[d]); end
                checks++; if (w_kill[d] !== m_kill[d]) begin
                    errors++; $display("FAIL rand_kill dut%0d cyc%0d got=%b exp=%b", d, c, w_kill[d], m_kill[d]); end
                if (m_pending[d]) begin
                    checks++; if (w_pc[d] !== m_pc[d]) begin
                        errors++; $display("FAIL rand_pc dut%0d cyc%0d got=%h exp=%h", d, c, w_pc[d], m_pc[d]); end
                end
`ifdef BRANCH_STATS_EN
                checks++; if (w_mis[d] !== 16'(m_cnt[d]) || w_stall[d] !== 16'(m_stall[d])) begin
                    errors++; $display("FAIL rand_stats dut%0d cyc%0d got=%0d/%0d exp=%0d/%0d",
                                       d, c, w_mis[d], w_stall[d], m_cnt[d], m_stall[d]); end
`endif
            end
        end
    endtask

    initial begin
        bv = 1'b0; bne = 4'b0000; rdy = 1'b0;
        for (int s = 0; s < 4; s++) tgt[s] = 32'd0;
        model_reset();
        test_reset();
        test_single_slot2();
        test_multi_flag();
        test_backpressure();
        test_edges();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
